// File: rtl/w5_fetch_if.sv
// w5_fetch_if: weight-ROM read port plus the weight stream towards the layer-5 engine.
// master = fetch controller, slave = ROM + compute engine side.
interface w5_fetch_if #(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned DATA_W = 960
);
  logic [ADDR_W-1:0] w5_raddr;
  logic [DATA_W-1:0] w5_rdata;
  logic [DATA_W-1:0] w5_wdata;
  logic              w5_wvalid;
  logic              w5_wready;
  logic              w5_wlast;

  modport master (
    output w5_raddr,
    input  w5_rdata,
    output w5_wdata,
    output w5_wvalid,
    input  w5_wready,
    output w5_wlast
  );

  modport slave (
    input  w5_raddr,
    output w5_rdata,
    input  w5_wdata,
    input  w5_wvalid,
    output w5_wready,
    input  w5_wlast
  );
endinterface

// File: rtl/w5_fetch.sv
// w5_fetch: read-side controller for the layer-5 weight ROM.
// Walks addresses 0..NUM_WORDS-1, absorbs ROM_LAT cycles of read latency through
// a credit-limited FIFO and streams the words out over valid/ready.
// Optional feature: define W5_FETCH_PERF_EN to add the w5_stall_cnt port.
module w5_fetch #(
  parameter int unsigned NUM_WORDS = 400,
  parameter int unsigned ADDR_W    = 9,
  parameter int unsigned DATA_W    = 960,
  parameter int unsigned ROM_LAT   = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        busy,
  output logic        done,
`ifdef W5_FETCH_PERF_EN
  output logic [15:0] w5_stall_cnt,
`endif
  w5_fetch_if.master  bus
);

  localparam int unsigned FIFO_DEPTH = ROM_LAT + 2;
  localparam int unsigned PTR_W      = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned ICNT_W     = ADDR_W + 1;
  localparam int unsigned LAST_IDX   = NUM_WORDS - 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t              state;
  logic [ICNT_W-1:0]   issue_cnt;
  logic [ADDR_W-1:0]   word_cnt;
  logic [CNT_W-1:0]    out_cnt;
  logic [CNT_W-1:0]    fifo_cnt;
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [ROM_LAT-1:0]  pipe;
  logic [DATA_W-1:0]   mem [FIFO_DEPTH];

  logic                start_acc;
  logic                issue;
  logic                push;
  logic                pop;
  logic                last_pop;
  logic [CNT_W-1:0]    fifo_cnt_nxt;
  logic [ADDR_W-1:0]   word_cnt_nxt;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Issue credit (start-of-cycle counts only), FIFO traffic and next-state counters.
  always_comb begin
    start_acc    = (state == IDLE) && start;
    issue        = (state == RUN) && (out_cnt < CNT_W'(FIFO_DEPTH));
    push         = pipe[ROM_LAT-1];
    pop          = bus.w5_wvalid && bus.w5_wready;
    last_pop     = pop && (word_cnt == ADDR_W'(LAST_IDX));
    fifo_cnt_nxt = fifo_cnt + CNT_W'(push) - CNT_W'(pop);
    word_cnt_nxt = start_acc ? '0 : word_cnt + ADDR_W'(pop);
  end

  // Pass control FSM with registered busy/done and the ROM address issue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      issue_cnt    <= '0;
      word_cnt     <= '0;
      bus.w5_raddr <= '0;
    end else begin
      done     <= 1'b0;
      word_cnt <= word_cnt_nxt;
      if (issue) begin
        bus.w5_raddr <= issue_cnt[ADDR_W-1:0];
        issue_cnt    <= issue_cnt + ICNT_W'(1);
      end
      case (state)
        IDLE: begin
          if (start) begin
            state     <= RUN;
            busy      <= 1'b1;
            issue_cnt <= '0;
          end
        end
        RUN: begin
          if (issue && (issue_cnt == ICNT_W'(LAST_IDX))) state <= DRAIN;
        end
        DRAIN: begin
          // The last word leaving implies nothing in flight and an empty FIFO.
          if (last_pop) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Latency pipe, credit counter, FIFO pointers and registered stream flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe          <= '0;
      out_cnt       <= '0;
      fifo_cnt      <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      bus.w5_wvalid <= 1'b0;
      bus.w5_wlast  <= 1'b0;
    end else begin
      pipe          <= (pipe << 1) | ROM_LAT'(issue);
      out_cnt       <= start_acc ? '0 : out_cnt + CNT_W'(issue) - CNT_W'(pop);
      fifo_cnt      <= fifo_cnt_nxt;
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      bus.w5_wvalid <= (fifo_cnt_nxt != '0);
      bus.w5_wlast  <= (fifo_cnt_nxt != '0) && (word_cnt_nxt == ADDR_W'(LAST_IDX));
    end
  end

  // FIFO storage; no reset needed since valid is tracked by fifo_cnt.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.w5_rdata;
  end

  assign bus.w5_wdata = mem[rd_ptr];

`ifdef W5_FETCH_PERF_EN
  // Backpressure cycles within a pass; saturating, cleared when a pass starts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w5_stall_cnt <= '0;
    end else if (start_acc) begin
      w5_stall_cnt <= '0;
    end else if (busy && bus.w5_wvalid && !bus.w5_wready && (w5_stall_cnt != 16'hFFFF)) begin
      w5_stall_cnt <= w5_stall_cnt + 16'd1;
    end
  end
`endif

  // Credit accounting must keep the FIFO from ever overflowing.
  always @(posedge clk) begin
    if (rst_n) assert (!(push && !pop && (fifo_cnt == CNT_W'(FIFO_DEPTH))));
  end

endmodule

// File: tb/tb_w5_fetch.sv
// tb_w5_fetch: scoreboard bench for w5_fetch.
// Instance 0: 400 words, ROM_LAT=1. Instance 1: 400 words, ROM_LAT=2.
// Instance 2: 1 word, ROM_LAT=1. ROM word content is the address replicated per 16-bit lane.
module tb_w5_fetch;
  localparam int unsigned ADDR_W = 9;
  localparam int unsigned DATA_W = 960;
  localparam int          NI     = 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NI-1:0]     start_v;
  logic [NI-1:0]     rdy_v;
  logic              busy_v [NI];
  logic              done_v [NI];
  logic              vld_v  [NI];
  logic              last_v [NI];
  logic [DATA_W-1:0] wd_v   [NI];
  logic [ADDR_W-1:0] ra_v   [NI];
`ifdef W5_FETCH_PERF_EN
  logic [15:0]       stall_v [NI];
`endif

  int   n_tests = 0;
  int   n_fail  = 0;
  int   sel, nw_sel, cyc, hs_cnt, done_cnt, first_vld, start_cyc, last_hs_cyc;
  logic last_hs_d;
  int   exp_q[$];

  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] rom_word(input logic [ADDR_W-1:0] a);
    return {(DATA_W/16){16'(a)}};
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int unsigned NW = (g == 2) ? 1 : 400;
    localparam int unsigned RL = (g == 1) ? 2 : 1;
    logic [ADDR_W-1:0] a_d;
    w5_fetch_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();
    w5_fetch #(.NUM_WORDS(NW), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ROM_LAT(RL)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .start(start_v[g]),
      .busy(busy_v[g]),
      .done(done_v[g]),
`ifdef W5_FETCH_PERF_EN
      .w5_stall_cnt(stall_v[g]),
`endif
      .bus(bus)
    );
    // ROM model: data for the address launched ROM_LAT-1 edges before the capture cycle.
    always @(posedge clk) a_d <= bus.w5_raddr;
    assign bus.w5_rdata  = rom_word((RL == 1) ? bus.w5_raddr : a_d);
    assign bus.w5_wready = rdy_v[g];
    assign vld_v[g]  = bus.w5_wvalid;
    assign last_v[g] = bus.w5_wlast;
    assign wd_v[g]   = bus.w5_wdata;
    assign ra_v[g]   = bus.w5_raddr;
  end

  // One cycle: sample at negedge, check done and handshakes against the scoreboard.
  task automatic tick();
    int idx;
    @(negedge clk);
    cyc++;
    n_tests++;
    assert (done_v[sel] === last_hs_d) else begin
      n_fail++; $error("FAIL done_pulse: got %b want %b (cycle %0d)", done_v[sel], last_hs_d, cyc);
    end
    if (done_v[sel] === 1'b1) begin
      done_cnt++;
      n_tests++;
      assert (busy_v[sel] === 1'b0) else begin
        n_fail++; $error("FAIL busy_at_done: got %b want 0", busy_v[sel]);
      end
    end
    if ((vld_v[sel] === 1'b1) && (first_vld < 0)) first_vld = cyc;
    last_hs_d = 1'b0;
    if ((vld_v[sel] === 1'b1) && (rdy_v[sel] === 1'b1)) begin
      n_tests++;
      assert (exp_q.size() > 0) else begin
        n_fail++; $error("FAIL extra_word: got word %0d, want none", wd_v[sel][15:0]);
      end
      if (exp_q.size() > 0) begin
        idx = exp_q.pop_front();
        n_tests++;
        assert (wd_v[sel] === rom_word(ADDR_W'(idx))) else begin
          n_fail++; $error("FAIL wdata: got %0d want %0d", wd_v[sel][15:0], idx);
        end
        n_tests++;
        assert (last_v[sel] === (idx == nw_sel - 1)) else begin
          n_fail++; $error("FAIL wlast: got %b at word %0d", last_v[sel], idx);
        end
        if (idx == nw_sel - 1) begin
          last_hs_d   = 1'b1;
          last_hs_cyc = cyc;
        end
        hs_cnt++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic start_pass();
    for (int i = 0; i < nw_sel; i++) exp_q.push_back(i);
    hs_cnt       = 0;
    first_vld    = -1;
    start_v[sel] = 1'b1;
    tick();
    start_cyc    = cyc;
    start_v[sel] = 1'b0;
  endtask

  task automatic run_until(input int target, input int budget, input bit rnd);
    for (int k = 0; (k < budget) && (hs_cnt < target); k++) begin
      if (rnd) rdy_v[sel] = 1'($urandom_range(0, 1));
      tick();
    end
    n_tests++;
    assert (hs_cnt == target) else begin
      n_fail++; $error("FAIL timeout: got %0d words want %0d", hs_cnt, target);
    end
  endtask

  task automatic check_int(input string tag, input int got, input int want);
    n_tests++;
    assert (got == want) else begin
      n_fail++; $error("FAIL %s: got %0d want %0d", tag, got, want);
    end
  endtask

  initial begin
    sel = 0; nw_sel = 400; cyc = 0; hs_cnt = 0; done_cnt = 0;
    first_vld = -1; start_cyc = 0; last_hs_cyc = 0; last_hs_d = 1'b0;
    start_v = '0; rdy_v = '0; rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) begin
      n_tests++;
      assert ({busy_v[i], done_v[i], vld_v[i], last_v[i]} === 4'b0000 && ra_v[i] === '0) else begin
        n_fail++; $error("FAIL reset_state: inst %0d got b%b d%b v%b l%b a%0d want all 0",
                         i, busy_v[i], done_v[i], vld_v[i], last_v[i], ra_v[i]);
      end
`ifdef W5_FETCH_PERF_EN
      check_int("reset_stall_cnt", int'(stall_v[i]), 0);
`endif
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Pass 1: stream with an ignored mid-pass start and a 20-cycle stall at word 100.
    sel = 0; nw_sel = 400; rdy_v[0] = 1'b1; done_cnt = 0;
    start_pass();
    run_until(50, 200, 1'b0);
    start_v[0] = 1'b1;
    tick();
    start_v[0] = 1'b0;
    run_until(100, 200, 1'b0);
    rdy_v[0] = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      n_tests++;
      assert ((vld_v[0] === 1'b1) && (wd_v[0] === rom_word(ADDR_W'(100)))) else begin
        n_fail++; $error("FAIL stall_hold: got v%b word %0d want v1 word 100", vld_v[0], wd_v[0][15:0]);
      end
    end
    check_int("stall_outstanding_raddr", int'(ra_v[0]), 102);
    rdy_v[0] = 1'b1;
    run_until(400, 1000, 1'b0);
    check_int("first_valid_lat1", first_vld - start_cyc, 3);
    check_int("queue_empty_pass1", exp_q.size(), 0);
`ifdef W5_FETCH_PERF_EN
    check_int("stall_cnt", int'(stall_v[0]), 20);
`endif

    // Pass 2: start coincides with the done of pass 1; full-rate stream.
    start_pass();
    check_int("done_count_pass1", done_cnt, 1);
    run_until(400, 1000, 1'b0);
    check_int("first_valid_pass2", first_vld - start_cyc, 3);
    check_int("last_handshake_cycle", last_hs_cyc - start_cyc, 402);
    tick();
    tick();
    check_int("done_count_pass2", done_cnt, 2);
`ifdef W5_FETCH_PERF_EN
    check_int("stall_cnt_cleared", int'(stall_v[0]), 0);
`endif

    // Pass 3: reset at word 200, then a clean restart.
    start_pass();
    run_until(200, 400, 1'b0);
    rst_n = 1'b0;
    #1;
    n_tests++;
    assert ({busy_v[0], done_v[0], vld_v[0], last_v[0]} === 4'b0000 && ra_v[0] === '0) else begin
      n_fail++; $error("FAIL midpass_reset: got b%b d%b v%b l%b a%0d want all 0",
                       busy_v[0], done_v[0], vld_v[0], last_v[0], ra_v[0]);
    end
    exp_q.delete();
    last_hs_d = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    done_cnt = 0;
    start_pass();
    run_until(400, 1000, 1'b0);
    check_int("first_valid_after_reset", first_vld - start_cyc, 3);
    tick();
    check_int("done_count_pass3", done_cnt, 1);

    // Pass 4: ROM_LAT=2 with random backpressure.
    rdy_v[0] = 1'b0;
    sel = 1; nw_sel = 400; rdy_v[1] = 1'b0; done_cnt = 0;
    start_pass();
    run_until(400, 5000, 1'b1);
    for (int k = 0; k < 5; k++) begin
      rdy_v[1] = 1'($urandom_range(0, 1));
      tick();
    end
    check_int("first_valid_lat2", first_vld - start_cyc, 4);
    check_int("done_count_lat2", done_cnt, 1);
    check_int("queue_empty_lat2", exp_q.size(), 0);

    // Pass 5: single-word configuration.
    rdy_v[1] = 1'b0;
    sel = 2; nw_sel = 1; rdy_v[2] = 1'b1; done_cnt = 0;
    start_pass();
    run_until(1, 20, 1'b0);
    tick();
    check_int("first_valid_one_word", first_vld - start_cyc, 3);
    check_int("done_count_one_word", done_cnt, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
